seg_scroll_ctrl: RTL and testbench



---
 rtl/seg_scroll_ctrl_pkg.sv | 31 +++
 rtl/hex7seg_dec.sv | 30 +++
 rtl/seg_scroll_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling seven-segment controller.
package seg_scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [6:0] BLANK_SEG  = 7'h7F;
  localparam logic [3:0] ANODES_OFF = 4'hF;
  localparam int         NUM_DIGITS = 4;
  localparam int         MSG_LEN    = 16;
  localparam int         DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int         IDX_W      = $clog2(MSG_LEN);

  // One anode pulled low for the scanned digit; an[3] is the leftmost digit.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [DIGIT_W-1:0] digit);
    logic [NUM_DIGITS-1:0] sel;
    sel        = ANODES_OFF;
    sel[digit] = 1'b0;
    return sel;
  endfunction

  // Digit k shows buffer entry scroll_pos+3-k; the 4-bit wrap gives the ring.
  function automatic logic [IDX_W-1:0] msg_index(input logic [IDX_W-1:0]   pos,
                                                 input logic [DIGIT_W-1:0] digit);
    return pos + IDX_W'(NUM_DIGITS - 1) - IDX_W'(digit);
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Hex digit to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex7seg_dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scans a 4-digit multiplexed display and scrolls a 16-entry hex message across it.
// Define SEG_DP_EN to add an active-low dp output marking buffer index 0.
//
//   state    | meaning
//   IDLE     | display blank, message buffer writable, waiting for start
//   RUN      | scanning and scrolling, buffer locked
//   STOPPING | still scanning; drops to IDLE at the next frame end
module seg_scroll_ctrl
  import seg_scroll_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = 16,
  parameter int SCROLL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_char,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic [3:0] scroll_pos,
  output logic [3:0] an,
  output logic [6:0] seg
`ifdef SEG_DP_EN
  ,
  output logic       dp
`endif
);

  localparam int PRESC_W = $clog2(CLK_DIV);
  localparam int FRAME_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SCROLL_FRAMES - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [IDX_W-1:0]     pos_q, pos_d;
  logic [3:0]           mem_q [MSG_LEN];

  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 busy_q, busy_d;
  logic                 wr_ready_q, wr_ready_d;

  logic                 scan_tick;
  logic                 frame_end;
  logic                 wr_fire;
  logic                 running_d;
  logic [IDX_W-1:0]     idx_d;
  logic [3:0]           char_d;
  logic [6:0]           glyph_d;

  assign wr_fire   = wr_valid && wr_ready_q;
  assign scan_tick = (presc_q == PRESC_LAST);
  assign frame_end = scan_tick && (digit_q == DIGIT_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    digit_d = digit_q;
    frame_d = frame_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          presc_d = '0;
          digit_d = '0;
          frame_d = '0;
          pos_d   = '0;
        end
      end
      ST_RUN, ST_STOPPING: begin
        // stop is taken before the frame-end exit check, so a stop on the
        // frame-end cycle buys one more full frame.
        if (state_q == ST_RUN && stop) begin
          state_d = ST_STOPPING;
        end else if (state_q == ST_STOPPING && frame_end) begin
          state_d = ST_IDLE;
        end
        presc_d = scan_tick ? '0 : presc_q + PRESC_W'(1);
        if (scan_tick) begin
          digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DIGIT_W'(1);
        end
        if (frame_end) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            pos_d   = pos_q + IDX_W'(1);
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end
        if (state_d == ST_IDLE) begin
          presc_d = '0;
          digit_d = '0;
          frame_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
        digit_d = '0;
        frame_d = '0;
        pos_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // counters; a same-cycle write is forwarded so it is visible on the first scan.
  assign running_d = (state_d != ST_IDLE);
  assign idx_d     = msg_index(pos_d, digit_d);
  assign char_d    = (wr_fire && (wr_addr == idx_d)) ? wr_char : mem_q[idx_d];

  hex7seg_dec u_dec (
    .hex_i (char_d),
    .seg_o (glyph_d)
  );

  always_comb begin
    an_d       = ANODES_OFF;
    seg_d      = BLANK_SEG;
    busy_d     = running_d;
    wr_ready_d = !running_d;
    if (running_d) begin
      an_d  = anode_sel(digit_d);
      seg_d = glyph_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      digit_q    <= '0;
      frame_q    <= '0;
      pos_q      <= '0;
      an_q       <= ANODES_OFF;
      seg_q      <= BLANK_SEG;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      pos_q      <= pos_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_char;
    end
  end

`ifdef SEG_DP_EN
  logic dp_q, dp_d;

  assign dp_d = !(running_d && (idx_d == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign dp = dp_q;
`endif

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign scroll_pos = pos_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl: vector table, directed scroll/stop/reset
// sequences and randomized episodes against a cycle-count arithmetic model.
module tb_seg_scroll_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int SF        = 2;
  localparam int FRAME_CYC = CLK_DIV * 4;
  localparam int NO_STOP   = 1 << 30;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [3:0] wr_char;
  logic       start;
  logic       stop;
  logic       busy;
  logic [3:0] scroll_pos;
  logic [3:0] an;
  logic [6:0] seg;
`ifdef SEG_DP_EN
  logic       dp;
`endif

  seg_scroll_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .SCROLL_FRAMES (SF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .scroll_pos (scroll_pos),
    .an         (an),
    .seg        (seg)
`ifdef SEG_DP_EN
    ,
    .dp         (dp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] mem_m [16];
  int         idle_pos = 0;
  int         last_pos = 0;

  typedef struct {
    logic       wv;
    logic [3:0] wa;
    logic [3:0] wc;
    logic       st;
    logic       sp;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_busy;
    logic       e_rdy;
    logic [3:0] e_pos;
  } vec_t;

  vec_t vt [49];

  function automatic logic [6:0] dec_ref(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic vec_t mk(input logic wv, input logic [3:0] wa, input logic [3:0] wc,
                              input logic st, input logic sp, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_busy, input logic e_rdy,
                              input logic [3:0] e_pos);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wc = wc; v.st = st; v.sp = sp;
    v.e_an = e_an; v.e_seg = e_seg; v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_pos = e_pos;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_busy, input logic e_rdy, input logic [3:0] e_pos);
    chk({nm, " an"},       32'(an),         32'(e_an));
    chk({nm, " seg"},      32'(seg),        32'(e_seg));
    chk({nm, " busy"},     32'(busy),       32'(e_busy));
    chk({nm, " wr_ready"}, 32'(wr_ready),   32'(e_rdy));
    chk({nm, " pos"},      32'(scroll_pos), 32'(e_pos));
  endtask

  // Expected outputs n cycles after the first RUN cycle, derived from elapsed
  // time: slot = n/CLK_DIV, frame = slot/4, scroll step = frame/SF.
  task automatic check_model(input string nm, input int n, input int end_n);
    int slot, dig, pos, idx;
    logic [3:0] e_an;
    if (n > end_n) begin
      pos = ((end_n + 1) / FRAME_CYC / SF) % 16;
      chk_all(nm, 4'hF, 7'h7F, 1'b0, 1'b1, 4'(pos));
`ifdef SEG_DP_EN
      chk({nm, " dp"}, 32'(dp), 32'd1);
`endif
    end else begin
      slot = n / CLK_DIV;
      dig  = slot % 4;
      pos  = (n / FRAME_CYC / SF) % 16;
      idx  = (pos + 3 - dig + 16) % 16;
      e_an = 4'hF;
      e_an[dig] = 1'b0;
      chk_all(nm, e_an, dec_ref(mem_m[idx]), 1'b1, 1'b0, 4'(pos));
`ifdef SEG_DP_EN
      chk({nm, " dp"}, 32'(dp), (idx == 0) ? 32'd0 : 32'd1);
`endif
    end
    last_pos = pos;
  endtask

  task automatic tick(input logic wv, input logic [3:0] wa, input logic [3:0] wc,
                      input logic st, input logic sp);
    wr_valid = wv; wr_addr = wa; wr_char = wc; start = st; stop = sp;
    @(posedge clk);
    #1;
    wr_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  // IDLE writes, start (optionally with a write), scan until stop takes effect.
  task automatic episode(input int n_wr, input logic wr_start, input int stop_at,
                         output int first_idle);
    logic       wv, st, sp;
    logic [3:0] a, c;
    int         end_n, p;
    first_idle = -1;
    for (int w = 0; w < n_wr; w++) begin
      wv = 1'($urandom_range(0, 1));
      a  = 4'($urandom);
      c  = 4'($urandom);
      tick(wv, a, c, 1'b0, 1'($urandom_range(0, 1)));
      if (wv) mem_m[a] = c;
      chk_all("idle", 4'hF, 7'h7F, 1'b0, 1'b1, 4'(idle_pos));
    end
    a = 4'($urandom);
    c = 4'($urandom);
    tick(wr_start, a, c, 1'b1, 1'b0);
    if (wr_start) mem_m[a] = c;
    end_n = stop_at + 1;
    while (end_n % FRAME_CYC != FRAME_CYC - 1) end_n++;
    check_model("run", 0, end_n);
    for (int n = 1; n <= end_n + 2; n++) begin
      p  = n - 1;
      wv = (p <= end_n) ? 1'($urandom_range(0, 1)) : 1'b0;
      st = (p <= end_n) ? ($urandom_range(0, 3) == 0) : 1'b0;
      sp = (p == stop_at) || (p > stop_at && p <= end_n && $urandom_range(0, 3) == 0);
      tick(wv, 4'($urandom), 4'($urandom), st, sp);
      check_model("run", n, end_n);
      if (first_idle < 0 && busy == 1'b0) first_idle = n;
    end
    idle_pos = last_pos;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int dg, fi, stop_at;
    logic [3:0] an_e;

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_char = '0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 4'(i);

    for (int i = 0; i < 16; i++)
      vt[i] = mk(1'b1, 4'(i), 4'(i), 1'b0, 1'b0, 4'hF, 7'h7F, 1'b0, 1'b1, 4'd0);
    for (int k = 0; k <= 32; k++) begin
      dg = (k / CLK_DIV) % 4;
      an_e = 4'hF;
      an_e[dg] = 1'b0;
      vt[16 + k] = mk((k == 20), (k == 20) ? 4'd5 : 4'd0, (k == 20) ? 4'hA : 4'd0,
                      (k == 0), 1'b0, an_e,
                      (k < 32) ? dec_ref(4'(3 - dg)) : dec_ref(4'd4),
                      1'b1, 1'b0, (k < 32) ? 4'd0 : 4'd1);
    end

    #10;
    chk_all("reset", 4'hF, 7'h7F, 1'b0, 1'b1, 4'd0);
    #13;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'd0, 4'd0, 1'b0, 1'($urandom_range(0, 1)));
      chk_all("idle_hold", 4'hF, 7'h7F, 1'b0, 1'b1, 4'd0);
    end

    for (int r = 0; r < 49; r++) begin
      tick(vt[r].wv, vt[r].wa, vt[r].wc, vt[r].st, vt[r].sp);
      chk_all("table", vt[r].e_an, vt[r].e_seg, vt[r].e_busy, vt[r].e_rdy, vt[r].e_pos);
    end

    // Continue the same run: wrap of scroll_pos, locked buffer, stop mid-frame.
    for (int n = 33; n <= 594; n++) begin
      tick((n >= 560 && n < 576), 4'd5, 4'hA, 1'b0, ((n - 1) == 580));
      check_model("scan", n, 591);
      case (n)
        448: begin chk("pos14 an0", 32'(an), 32'hE); chk("pos14 seg0", 32'(seg), 32'h79); end
        452: begin chk("pos14 an1", 32'(an), 32'hD); chk("pos14 seg1", 32'(seg), 32'h40); end
        456: begin chk("pos14 an2", 32'(an), 32'hB); chk("pos14 seg2", 32'(seg), 32'h0E); end
        460: begin chk("pos14 an3", 32'(an), 32'h7); chk("pos14 seg3", 32'(seg), 32'h06); end
        511: chk("pos before wrap", 32'(scroll_pos), 32'd15);
        512: chk("pos after wrap", 32'(scroll_pos), 32'd0);
        576: chk("mem5 kept", 32'(seg), 32'h12);
        591: chk("stop last busy", 32'(busy), 32'd1);
        592: begin chk("stop blank an", 32'(an), 32'hF); chk("stop busy", 32'(busy), 32'd0); end
        default: ;
      endcase
    end
    idle_pos = last_pos;

    episode(4, 1'b0, 5, fi);
    chk("stop mid-frame idle cycle", 32'(fi), 32'd16);
    episode(3, 1'b1, 15, fi);
    chk("stop at frame end idle cycle", 32'(fi), 32'd32);

    for (int e = 0; e < 8; e++) begin
      stop_at = $urandom_range(0, 700);
      if ($urandom_range(0, 2) == 0) stop_at = (stop_at / FRAME_CYC) * FRAME_CYC + FRAME_CYC - 1;
      episode($urandom_range(0, 20), 1'($urandom_range(0, 1)), stop_at, fi);
    end

    // Asynchronous reset in the middle of a run.
    tick(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 4'hF, 7'h7F, 1'b0, 1'b1, 4'd0);
`ifdef SEG_DP_EN
    chk("async reset dp", 32'(dp), 32'd1);
`endif
    @(posedge clk);
    #3;
    chk_all("held reset", 4'hF, 7'h7F, 1'b0, 1'b1, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 4'd0;
    idle_pos = 0;
    episode(0, 1'b0, 5, fi);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
